pong_game: RTL
==============

# pong_game

Parametrised two-player Pong core for the Go Board VGA path: owns ball, two paddles, scores and a match state machine on a GAME_WIDTH × GAME_HEIGHT cell grid. It sits between the pixel-to-cell scaler, which supplies i_row/i_col, and the VGA colour mux, which consumes o_draw. Scores also drive the 7-segment display.

## Interface
- GAME_WIDTH, 40: grid columns; 8..63.
- GAME_HEIGHT, 40: grid rows; 8..63.
- PADDLE_HEIGHT, 6: paddle length in cells; less than GAME_HEIGHT.
- BALL_SPEED, 1250000: clocks per ball step; at least 2.
- PADDLE_SPEED, 625000: clocks per paddle step while a button is held; at least 2.
- SERVE_DELAY, 25000000: clocks held in POINT before re-serve.
- SCORE_LIMIT, 9: winning score; 1..15.
- i_clk  in  1  system clock (25 MHz).
- i_rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- i_start  in  1  single-cycle start/restart pulse, debounced upstream, synchronous to i_clk.
- i_p1_up, i_p1_down, i_p2_up, i_p2_down  in  1 each  level inputs, debounced upstream, synchronous to i_clk.
- i_row, i_col  in  6 each  cell currently being scanned.
- o_draw  out  1  cell (i_row, i_col) is ball or paddle; registered.
- o_p1_score, o_p2_score  out  4 each  scores.
- o_state  out  2  IDLE=0, RUNNING=1, POINT=2, OVER=3.

## Operation
- Reset values: o_draw=0, scores=0, o_state=IDLE, ball=(GAME_WIDTH/2, GAME_HEIGHT/2), direction +x +y, both paddle tops=(GAME_HEIGHT-PADDLE_HEIGHT)/2 (17 with defaults), all counters=0.
- Paddles: P1 at column 0, P2 at column GAME_WIDTH-1. Each paddle owns a free-running PADDLE_SPEED counter.
  - On counter wrap: up held and down not held → top−1, clamped at 0.
  - Down held and up not held → top+1, clamped at GAME_HEIGHT-PADDLE_HEIGHT.
  - Both held or neither held → no move.
  - Paddles move in every state.
- Ball: moves only in RUNNING, on each BALL_SPEED wrap. The counter is cleared on every entry into RUNNING. X and Y are evaluated on the same step.
- Y axis:
  - Moving up at row 0 → direction becomes down, row=1.
  - Moving down at row GAME_HEIGHT-1 → direction becomes up, row=GAME_HEIGHT-2.
  - Otherwise row ±1.
- X axis, moving left at column 1:
  - Hit when P1 top ≤ ball row < P1 top+PADDLE_HEIGHT, using the pre-step row → direction becomes right, column=2.
  - Miss → column=0, o_p2_score+1, go to POINT.
- X axis, moving right at column GAME_WIDTH-2: mirror of the left case using P2; a miss increments o_p1_score.
- X axis, otherwise: column ±1.
- FSM:
  - IDLE: i_start → RUNNING.
  - RUNNING: miss → POINT.
  - POINT: waits SERVE_DELAY clocks. Then, if the scorer's score equals SCORE_LIMIT → OVER. Otherwise the ball re-centres, X direction points toward the player who conceded, Y direction is unchanged, and the FSM goes to RUNNING.
  - OVER: ball frozen. i_start → IDLE with scores cleared and ball re-centred.
  - i_start is ignored in RUNNING and POINT.
- Score arithmetic: 4-bit, saturating at SCORE_LIMIT.
- o_draw is registered. It is 1 when (i_row, i_col) equals the ball position, or lies in either paddle column within that paddle's span.
- Reset asserted mid-operation returns every output to its reset value asynchronously.

## Timing
- o_draw: 1-cycle latency from i_row/i_col. It uses ball and paddle positions as they stand on that same clock edge.
- Ball, paddle and score updates become visible one clock after the counter-wrap cycle.
- A score increment and the entry into POINT happen on the same edge.
- Ball step and paddle step in the same cycle: the collision uses the paddle top from before the edge.
- POINT dwell: exactly SERVE_DELAY clocks from entry to the re-serve edge.

## Structure
- Shared package pong_pkg holds:
  - the state encoding (IDLE, RUNNING, POINT, OVER);
  - direction constants DIR_NEG=0, DIR_POS=1;
  - the coordinate width constant COORD_W=6;
  - the score width constant SCORE_W=4.
- Sub-module pong_paddle is instantiated twice. Ports: i_clk, i_rst_n, i_up, i_down, o_top. Parameters: GAME_HEIGHT, PADDLE_HEIGHT, PADDLE_SPEED.
- Ball logic, FSM, scoring and the draw compare stay in pong_game.

## Test plan
Bench parameters: BALL_SPEED=4, PADDLE_SPEED=2, SERVE_DELAY=8, SCORE_LIMIT=2, defaults otherwise.
- Reset, then release → ball (20,20), paddle tops 17, scores 0, o_state=0. Scanning (20,20) gives o_draw=1 one clock later; (10,10) gives o_draw=0.
- Hold i_p1_up for 40 clocks → P1 top reaches 0 and stays 0. Hold up and down together → no change.
- Ball moving down at row 39 → next step row 38, direction up. Row 0 moving up → row 1.
- Ball moving left at column 1, row 20, P1 top 17 → column 2, direction right, no score change.
- Same case with P1 top 0 → column 0, o_p2_score=1, o_state=2 for 8 clocks, then re-centre and move left.
- Second P2 point → o_state=3 and ball frozen. i_start → o_state=0 and scores 0. Assert i_rst_n low mid-RUNNING → all outputs at reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, ball record and span helper for the Pong core.
package pong_pkg;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned SPAN_W  = COORD_W + 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUNNING = 2'd1;
    localparam logic [1:0] POINT   = 2'd2;
    localparam logic [1:0] OVER    = 2'd3;

    localparam logic DIR_NEG = 1'b0;
    localparam logic DIR_POS = 1'b1;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               dx;
        logic               dy;
    } ball_t;

    // True when pos lies in [top, top+len); widened so top+len cannot wrap.
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] top,
                                     input logic [SPAN_W-1:0]  len);
        logic [SPAN_W-1:0] pos_w;
        logic [SPAN_W-1:0] top_w;
        pos_w = {1'b0, pos};
        top_w = {1'b0, top};
        return (pos_w >= top_w) && (pos_w < top_w + len);
    endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: free-running step timer and clamped top-row position.
module pong_paddle
    import pong_pkg::*;
#(
    parameter int unsigned GAME_HEIGHT   = 40,
    parameter int unsigned PADDLE_HEIGHT = 6,
    parameter int unsigned PADDLE_SPEED  = 625000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_up,
    input  logic               i_down,
    output logic [COORD_W-1:0] o_top
);

    localparam int unsigned        CNT_W    = (PADDLE_SPEED > 1) ? $clog2(PADDLE_SPEED) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(PADDLE_SPEED - 1);
    localparam logic [COORD_W-1:0] TOP_MAX  = COORD_W'(GAME_HEIGHT - PADDLE_HEIGHT);
    localparam logic [COORD_W-1:0] TOP_RST  = COORD_W'((GAME_HEIGHT - PADDLE_HEIGHT) / 2);

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COORD_W-1:0] top_q, top_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            top_q <= TOP_RST;
        end else begin
            cnt_q <= cnt_d;
            top_q <= top_d;
        end
    end

    // Exactly one direction held moves the paddle one row per timer wrap.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        top_d = top_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (i_up && !i_down && (top_q != '0)) begin
                top_d = top_q - COORD_W'(1);
            end else if (i_down && !i_up && (top_q != TOP_MAX)) begin
                top_d = top_q + COORD_W'(1);
            end
        end
    end

    assign o_top = top_q;

endmodule

// File: rtl/pong_game.sv
// Two-player Pong core: ball motion, collisions, scoring, match FSM and cell draw.
module pong_game
    import pong_pkg::*;
#(
    parameter int unsigned GAME_WIDTH    = 40,
    parameter int unsigned GAME_HEIGHT   = 40,
    parameter int unsigned PADDLE_HEIGHT = 6,
    parameter int unsigned BALL_SPEED    = 1250000,
    parameter int unsigned PADDLE_SPEED  = 625000,
    parameter int unsigned SERVE_DELAY   = 25000000,
    parameter int unsigned SCORE_LIMIT   = 9
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_p1_up,
    input  logic               i_p1_down,
    input  logic               i_p2_up,
    input  logic               i_p2_down,
    input  logic [COORD_W-1:0] i_row,
    input  logic [COORD_W-1:0] i_col,
    output logic               o_draw,
    output logic [SCORE_W-1:0] o_p1_score,
    output logic [SCORE_W-1:0] o_p2_score,
    output logic [1:0]         o_state
);

    localparam int unsigned        BALL_W    = (BALL_SPEED > 1) ? $clog2(BALL_SPEED) : 1;
    localparam int unsigned        SRV_W     = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [BALL_W-1:0]  BALL_LAST = BALL_W'(BALL_SPEED - 1);
    localparam logic [SRV_W-1:0]   SRV_LAST  = SRV_W'(SERVE_DELAY - 1);
    localparam logic [COORD_W-1:0] X_MAX     = COORD_W'(GAME_WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX     = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [COORD_W-1:0] X_CTR     = COORD_W'(GAME_WIDTH / 2);
    localparam logic [COORD_W-1:0] Y_CTR     = COORD_W'(GAME_HEIGHT / 2);
    localparam logic [SPAN_W-1:0]  PAD_LEN   = SPAN_W'(PADDLE_HEIGHT);
    localparam logic [SCORE_W-1:0] LIMIT     = SCORE_W'(SCORE_LIMIT);

    logic [1:0]         state_q, state_d;
    ball_t              ball_q, ball_d;
    logic [BALL_W-1:0]  ball_cnt_q, ball_cnt_d;
    logic [SRV_W-1:0]   srv_cnt_q, srv_cnt_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic               p2_scored_q, p2_scored_d;
    logic               draw_q, draw_d;
    logic [COORD_W-1:0] p1_top, p2_top;

    pong_paddle #(
        .GAME_HEIGHT  (GAME_HEIGHT),
        .PADDLE_HEIGHT(PADDLE_HEIGHT),
        .PADDLE_SPEED (PADDLE_SPEED)
    ) u_p1 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_up   (i_p1_up),
        .i_down (i_p1_down),
        .o_top  (p1_top)
    );

    pong_paddle #(
        .GAME_HEIGHT  (GAME_HEIGHT),
        .PADDLE_HEIGHT(PADDLE_HEIGHT),
        .PADDLE_SPEED (PADDLE_SPEED)
    ) u_p2 (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_up   (i_p2_up),
        .i_down (i_p2_down),
        .o_top  (p2_top)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            ball_q      <= '{x: X_CTR, y: Y_CTR, dx: DIR_POS, dy: DIR_POS};
            ball_cnt_q  <= '0;
            srv_cnt_q   <= '0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            p2_scored_q <= 1'b0;
            draw_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_q      <= ball_d;
            ball_cnt_q  <= ball_cnt_d;
            srv_cnt_q   <= srv_cnt_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            p2_scored_q <= p2_scored_d;
            draw_q      <= draw_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ball_d      = ball_q;
        ball_cnt_d  = '0;
        srv_cnt_d   = '0;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        p2_scored_d = p2_scored_q;

        draw_d = ((i_row == ball_q.y) && (i_col == ball_q.x))
              || ((i_col == '0)    && in_span(i_row, p1_top, PAD_LEN))
              || ((i_col == X_MAX) && in_span(i_row, p2_top, PAD_LEN));

        case (state_q)
            IDLE: begin
                if (i_start) state_d = RUNNING;
            end
            RUNNING: begin
                ball_cnt_d = ball_cnt_q + BALL_W'(1);
                if (ball_cnt_q == BALL_LAST) begin
                    ball_cnt_d = '0;
                    if (ball_q.dy == DIR_NEG) begin
                        if (ball_q.y == '0) begin
                            ball_d.dy = DIR_POS;
                            ball_d.y  = COORD_W'(1);
                        end else begin
                            ball_d.y = ball_q.y - COORD_W'(1);
                        end
                    end else begin
                        if (ball_q.y == Y_MAX) begin
                            ball_d.dy = DIR_NEG;
                            ball_d.y  = Y_MAX - COORD_W'(1);
                        end else begin
                            ball_d.y = ball_q.y + COORD_W'(1);
                        end
                    end
                    // Collision tests use the pre-step row and the paddle top before this edge.
                    if (ball_q.dx == DIR_NEG) begin
                        if (ball_q.x == COORD_W'(1)) begin
                            if (in_span(ball_q.y, p1_top, PAD_LEN)) begin
                                ball_d.dx = DIR_POS;
                                ball_d.x  = COORD_W'(2);
                            end else begin
                                ball_d.x    = '0;
                                p2_score_d  = (p2_score_q < LIMIT) ? p2_score_q + SCORE_W'(1) : p2_score_q;
                                p2_scored_d = 1'b1;
                                state_d     = POINT;
                            end
                        end else begin
                            ball_d.x = ball_q.x - COORD_W'(1);
                        end
                    end else begin
                        if (ball_q.x == X_MAX - COORD_W'(1)) begin
                            if (in_span(ball_q.y, p2_top, PAD_LEN)) begin
                                ball_d.dx = DIR_NEG;
                                ball_d.x  = X_MAX - COORD_W'(2);
                            end else begin
                                ball_d.x    = X_MAX;
                                p1_score_d  = (p1_score_q < LIMIT) ? p1_score_q + SCORE_W'(1) : p1_score_q;
                                p2_scored_d = 1'b0;
                                state_d     = POINT;
                            end
                        end else begin
                            ball_d.x = ball_q.x + COORD_W'(1);
                        end
                    end
                end
            end
            POINT: begin
                srv_cnt_d = srv_cnt_q + SRV_W'(1);
                if (srv_cnt_q == SRV_LAST) begin
                    srv_cnt_d = '0;
                    if ((p2_scored_q ? p2_score_q : p1_score_q) == LIMIT) begin
                        state_d = OVER;
                    end else begin
                        // Serve toward the player who just conceded.
                        ball_d.x  = X_CTR;
                        ball_d.y  = Y_CTR;
                        ball_d.dx = p2_scored_q ? DIR_NEG : DIR_POS;
                        state_d   = RUNNING;
                    end
                end
            end
            OVER: begin
                if (i_start) begin
                    state_d    = IDLE;
                    p1_score_d = '0;
                    p2_score_d = '0;
                    ball_d.x   = X_CTR;
                    ball_d.y   = Y_CTR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_draw     = draw_q;
    assign o_p1_score = p1_score_q;
    assign o_p2_score = p2_score_q;
    assign o_state    = state_q;

endmodule
